// File: rtl/fir_job_sequencer_pkg.sv
// Shared types and sizing for the FIR job sequencer: state encoding, latched job
// configuration and the helpers used to validate a job and size its output count.
package fir_job_sequencer_pkg;

  localparam int NB_TAPS   = 50;
  localparam int CNT_WIDTH = 16;
  localparam int TAP_WIDTH = $clog2(NB_TAPS + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_H,
    LOAD_H,
    REQ_XY,
    RUN,
    DRAIN,
    DONE
  } fir_seq_state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] nb_samples;
    logic [TAP_WIDTH-1:0] nb_taps;
  } fir_seq_cfg_t;

  // A job must have at least one tap, fit the tap buffer, and supply enough samples
  // for at least one full-window output.
  function automatic logic cfg_valid(input logic [CNT_WIDTH-1:0] nb_samples,
                                     input logic [TAP_WIDTH-1:0] nb_taps);
    return (nb_taps != '0) && (nb_taps <= TAP_WIDTH'(NB_TAPS)) &&
           (nb_samples >= CNT_WIDTH'(nb_taps));
  endfunction

  function automatic logic [CNT_WIDTH-1:0] expected_outputs(input fir_seq_cfg_t cfg);
    return cfg.nb_samples - CNT_WIDTH'(cfg.nb_taps) + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fir_job_sequencer.sv
// Sequences one FIR job: tap preload, x streaming with y write-back counting, and
// completion. All outputs are registered so no ready input reaches an output combinationally.
module fir_job_sequencer
  import fir_job_sequencer_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] nb_samples_i,
  input  logic [TAP_WIDTH-1:0] nb_taps_i,
  output logic                 h_req_start_o,
  input  logic                 h_ready_start_i,
  input  logic                 h_done_i,
  input  logic                 taps_full_i,
  output logic                 xy_req_start_o,
  input  logic                 xy_ready_start_i,
  input  logic                 y_valid_i,
  input  logic                 y_ready_i,
  input  logic                 y_done_i,
  output logic                 dp_enable_o,
  output logic                 dp_clear_o,
  output logic [TAP_WIDTH-1:0] dp_nb_taps_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  fir_seq_state_e       state_reg;
  fir_seq_cfg_t         cfg_reg;
  logic [CNT_WIDTH-1:0] y_cnt_reg;
  logic [CNT_WIDTH-1:0] y_cnt_inc;
  logic [CNT_WIDTH-1:0] y_exp;
  logic                 h_done_seen_reg;
  logic                 taps_full_seen_reg;
  logic                 y_done_seen_reg;
  logic                 h_req_reg;
  logic                 xy_req_reg;
  logic                 dp_enable_reg;
  logic                 dp_clear_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic y_hs;
  logic h_done_any;
  logic taps_full_any;
  logic y_done_any;

  assign y_hs          = y_valid_i && y_ready_i;
  assign h_done_any    = h_done_seen_reg || h_done_i;
  assign taps_full_any = taps_full_seen_reg || taps_full_i;
  assign y_done_any    = y_done_seen_reg || y_done_i;
  assign y_cnt_inc     = y_cnt_reg + CNT_WIDTH'(1);
  assign y_exp         = expected_outputs(cfg_reg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= IDLE;
      cfg_reg            <= '0;
      y_cnt_reg          <= '0;
      h_done_seen_reg    <= 1'b0;
      taps_full_seen_reg <= 1'b0;
      y_done_seen_reg    <= 1'b0;
      h_req_reg          <= 1'b0;
      xy_req_reg         <= 1'b0;
      dp_enable_reg      <= 1'b0;
      dp_clear_reg       <= 1'b0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else if (clear_i) begin
      state_reg          <= IDLE;
      cfg_reg            <= '0;
      y_cnt_reg          <= '0;
      h_done_seen_reg    <= 1'b0;
      taps_full_seen_reg <= 1'b0;
      y_done_seen_reg    <= 1'b0;
      h_req_reg          <= 1'b0;
      xy_req_reg         <= 1'b0;
      dp_enable_reg      <= 1'b0;
      dp_clear_reg       <= 1'b0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      dp_clear_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            if (cfg_valid(nb_samples_i, nb_taps_i)) begin
              cfg_reg            <= '{nb_samples: nb_samples_i, nb_taps: nb_taps_i};
              y_cnt_reg          <= '0;
              h_done_seen_reg    <= 1'b0;
              taps_full_seen_reg <= 1'b0;
              y_done_seen_reg    <= 1'b0;
              dp_clear_reg       <= 1'b1;
              h_req_reg          <= 1'b1;
              busy_reg           <= 1'b1;
              state_reg          <= REQ_H;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        REQ_H: begin
          h_done_seen_reg    <= h_done_any;
          taps_full_seen_reg <= taps_full_any;
          if (h_ready_start_i) begin
            h_req_reg <= 1'b0;
            state_reg <= LOAD_H;
          end
        end
        LOAD_H: begin
          // Tap-buffer-full and h-source-done may arrive in either order.
          h_done_seen_reg    <= h_done_any;
          taps_full_seen_reg <= taps_full_any;
          if (h_done_any && taps_full_any) begin
            xy_req_reg    <= 1'b1;
            dp_enable_reg <= 1'b1;
            state_reg     <= REQ_XY;
          end
        end
        REQ_XY: begin
          y_done_seen_reg <= y_done_any;
          if (xy_ready_start_i) begin
            xy_req_reg <= 1'b0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          y_done_seen_reg <= y_done_any;
          if (y_hs) begin
            y_cnt_reg <= y_cnt_inc;
            if (y_cnt_inc == y_exp) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          y_done_seen_reg <= y_done_any;
          if (y_done_any) begin
            done_reg      <= 1'b1;
            dp_enable_reg <= 1'b0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          busy_reg        <= 1'b0;
          y_done_seen_reg <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign h_req_start_o  = h_req_reg;
  assign xy_req_start_o = xy_req_reg;
  assign dp_enable_o    = dp_enable_reg;
  assign dp_clear_o     = dp_clear_reg;
  assign dp_nb_taps_o   = cfg_reg.nb_taps;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign err_o          = err_reg;

endmodule
